// File: rtl/exc_track.sv
// -----------------------------------------------------------------------------
// exc_track
//
// Exception and interrupt tracker for a five-stage MIPS pipeline.
// Faults are detected in F (fetch address), D (reserved instruction and
// syscall) and E (data address and arithmetic overflow). Each fault travels
// down a D/E/M register chain together with its PC and delay-slot flag. A
// stage only checks for a new fault when nothing earlier has already faulted,
// so the earliest-stage fault wins. At M the masked hardware interrupts are
// merged in, and a single request with code, EPC and BD goes to CP0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   en_D                D register load enable (low = stall)
//   clr_D/clr_E/clr_M   per-stage flush from the hazard unit
//   pc_F, bd_F          fetch PC and its delay-slot flag
//   ri_D, sys_D         reserved instruction / syscall from the decoder
//   mem_op_E, mem_sz_E  E-stage memory operation and access size
//   addr_E              E-stage data address
//   ovf_E, ovchk_E      ALU overflow, instruction traps on overflow
//   hw_int, im, ie, exl interrupt lines, mask and CP0 status bits
//   req                 take an exception or interrupt this cycle
//   code, epc, bd       ExcCode, return PC and delay-slot flag for CP0
//   clr_instr_D         the D instruction must decode as a nop
// -----------------------------------------------------------------------------
module exc_track #(
   parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
   parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
   parameter logic [31:0] DM_HI      = 32'h0000_2fff,
   parameter int          NDEV       = 2,
   parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
   parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
   parameter int          DEV_SIZE   = 12,
   parameter int          DEV_RO_OFF = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_D,
   input  logic        clr_D,
   input  logic        clr_E,
   input  logic        clr_M,
   input  logic [31:0] pc_F,
   input  logic        bd_F,
   input  logic        ri_D,
   input  logic        sys_D,
   input  logic [1:0]  mem_op_E,
   input  logic [1:0]  mem_sz_E,
   input  logic [31:0] addr_E,
   input  logic        ovf_E,
   input  logic        ovchk_E,
   input  logic [5:0]  hw_int,
   input  logic [5:0]  im,
   input  logic        ie,
   input  logic        exl,
   output logic        req,
   output logic [4:0]  code,
   output logic [31:0] epc,
   output logic        bd,
   output logic        clr_instr_D
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;

   // Stage registers
   logic [4:0]  code_D, code_E, code_M;
   logic [31:0] pc_D, pc_E, pc_M;
   logic        bd_D, bd_E, bd_M;
   logic        valid_D, valid_E, valid_M;

   // Per-stage code after that stage's own check
   logic [4:0]  f_code, d_code, e_code;

   logic        int_p;
   logic        flush;

   // ---------------------------------------------------------------- F check
   always_comb begin
      f_code = EXC_NONE;
      if (pc_F[1:0] != 2'b00 || pc_F < TEXT_LO || pc_F > TEXT_HI)
         f_code = EXC_ADEL;
   end

   // ---------------------------------------------------------------- D check
   always_comb begin
      d_code = code_D;
      if (code_D == EXC_NONE) begin
         if (ri_D)
            d_code = EXC_RI;
         else if (sys_D)
            d_code = EXC_SYS;
      end
   end

   // ---------------------------------------------------------------- E check
   logic [31:0] dev_base;
   logic        in_dev;
   logic        ro_hit;
   logic        in_dm;
   logic        misaligned;
   logic        addr_bad;
   logic        is_load, is_store;

   always_comb begin
      dev_base = '0;
      in_dev   = 1'b0;
      ro_hit   = 1'b0;
      for (int k = 0; k < NDEV; k++) begin
         dev_base = DEV_BASE + DEV_STRIDE * 32'(k);
         if (addr_E >= dev_base && addr_E <= dev_base + 32'(DEV_SIZE) - 32'd1)
            in_dev = 1'b1;
         // A word store touching any byte of the read-only word faults.
         if (addr_E >= dev_base + 32'(DEV_RO_OFF) &&
             addr_E <= dev_base + 32'(DEV_RO_OFF) + 32'd3)
            ro_hit = 1'b1;
      end
   end

   always_comb begin
      is_load    = (mem_op_E == OP_LOAD);
      is_store   = (mem_op_E == OP_STORE);
      in_dm      = (addr_E <= DM_HI);
      misaligned = (mem_sz_E == SZ_WORD && addr_E[1:0] != 2'b00) ||
                   (mem_sz_E == SZ_HALF && addr_E[0]);
      // ovf_E here means the address computation itself wrapped.
      addr_bad   = misaligned | ovf_E | ~(in_dm | in_dev) |
                   (in_dev & (mem_sz_E != SZ_WORD));
   end

   always_comb begin
      e_code = code_E;
      if (code_E == EXC_NONE) begin
         if (is_load && addr_bad)
            e_code = EXC_ADEL;
         else if (is_store && (addr_bad || ro_hit))
            e_code = EXC_ADES;
         else if (mem_op_E == OP_NONE && ovchk_E && ovf_E)
            e_code = EXC_OV;
      end
   end

   // ---------------------------------------------------------------- M merge
   always_comb begin
      int_p       = (|(hw_int & im)) & ie & ~exl;
      req         = valid_M & ~exl & (int_p | (code_M != EXC_NONE));
      code        = int_p ? EXC_INT : code_M;
      epc         = bd_M ? (pc_M - 32'd4) : pc_M;
      bd          = bd_M;
      clr_instr_D = (code_D != EXC_NONE) | ri_D | sys_D;
      // CP0 takes the request in the same cycle, so everything younger
      // than M is discarded on the following edge.
      flush       = req;
   end

   // ---------------------------------------------------------------- registers
   // A cleared stage keeps its pc so the slot still reports a sensible
   // address if it reaches M as a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         code_D  <= EXC_NONE;
         pc_D    <= TEXT_LO;
         bd_D    <= 1'b0;
         valid_D <= 1'b0;
         code_E  <= EXC_NONE;
         pc_E    <= TEXT_LO;
         bd_E    <= 1'b0;
         valid_E <= 1'b0;
         code_M  <= EXC_NONE;
         pc_M    <= TEXT_LO;
         bd_M    <= 1'b0;
         valid_M <= 1'b0;
      end else begin
         if (clr_D || flush) begin
            code_D  <= EXC_NONE;
            bd_D    <= 1'b0;
            valid_D <= 1'b0;
         end else if (en_D) begin
            code_D  <= f_code;
            pc_D    <= pc_F;
            bd_D    <= bd_F;
            valid_D <= 1'b1;
         end

         if (clr_E || flush) begin
            code_E  <= EXC_NONE;
            bd_E    <= 1'b0;
            valid_E <= 1'b0;
         end else begin
            code_E  <= d_code;
            pc_E    <= pc_D;
            bd_E    <= bd_D;
            valid_E <= valid_D;
         end

         if (clr_M || flush) begin
            code_M  <= EXC_NONE;
            bd_M    <= 1'b0;
            valid_M <= 1'b0;
         end else begin
            code_M  <= e_code;
            pc_M    <= pc_E;
            bd_M    <= bd_E;
            valid_M <= valid_E;
         end
      end
   end

endmodule

// File: doc/exc_track.md
# exc_track

Parametrised exception/interrupt tracker for the five-stage MIPS pipeline. It detects fetch, decode, memory-address and overflow exceptions and carries each code, PC and delay-slot flag down a D/E/M register chain; the earliest-stage exception wins. At M it merges masked hardware interrupts and presents one request, with code, EPC and BD, to CP0. The address map and the number of device windows are parameters.

## Interface
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address
- DM_HI, 32'h0000_2fff, data memory spans 0..DM_HI
- NDEV, 2, number of device windows
- DEV_BASE, 32'h0000_7f00, base address of device window 0
- DEV_STRIDE, 32'h10, distance between consecutive window bases
- DEV_SIZE, 12, bytes per window; the legal range is base..base+DEV_SIZE-1
- DEV_RO_OFF, 8, offset of the read-only word within each window
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en_D, clr_D, clr_E, clr_M  in  1 each  stall/flush controls from the hazard unit
- pc_F  in  32  fetch PC
- bd_F  in  1  the fetched instruction is in a delay slot
- ri_D, sys_D  in  1 each  unknown instruction / syscall, from the decoder
- mem_op_E  in  2  00 none, 01 load, 10 store
- mem_sz_E  in  2  00 byte, 01 half, 10 word
- addr_E  in  32  computed data address
- ovf_E  in  1  ALU 32-bit overflow
- ovchk_E  in  1  instruction traps on overflow (add/addi/sub)
- hw_int  in  6  device interrupt lines
- im  in  6  interrupt mask, from CP0
- ie, exl  in  1 each  from CP0
- req  out  1  take an exception or interrupt this cycle
- code  out  5  ExcCode
- epc  out  32  return PC
- bd  out  1  M-stage instruction is in a delay slot
- clr_instr_D  out  1  the D instruction carries an exception and must decode as nop

## Operation
- Codes: Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12. Code 0 with valid=1 means no exception.
- F check: AdEL when pc_F[1:0]≠0 or pc_F is outside TEXT_LO..TEXT_HI.
- D check: applied only if no code arrived from F. RI has priority over Syscall.
- E check: applied only if no code arrived from D. Priority order: AdEL/AdES, then Ov.
  - A load raises AdEL and a store raises AdES when any of these holds:
    - misaligned: word with addr[1:0]≠0, or half with addr[0]≠0
    - ovf_E=1
    - address inside neither 0..DM_HI nor any device window k in 0..NDEV-1
    - half or byte access to a device window
  - A store also raises AdES when it writes any address from base_k+DEV_RO_OFF to base_k+DEV_RO_OFF+3.
  - Ov = ovchk_E & ovf_E, with no memory op.
- Each stage register holds code, pc, bd and valid.
  - D loads from F when en_D=1 and holds otherwise.
  - E and M load every cycle.
  - A clr input, or a flush, writes code 0, valid 0 and bd 0, and keeps pc unchanged. A clear always overrides en_D.
- Interrupt: int_p = |(hw_int & im) & ie & ~exl.
- req = valid_M & ~exl & (int_p | code_M≠0). Interrupts beat exceptions: while int_p=1, code=0.
- epc = bd_M ? pc_M-4 : pc_M. bd = bd_M.
- On the edge after req=1, all D/E/M registers flush. The external clr inputs are ORed with this flush.
- clr_instr_D = (code_D≠0) | ri_D | sys_D.

## Timing
- Reset (synchronous): all code and valid bits are 0, bd is 0, pc is TEXT_LO. The outputs then read req 0, code 0, epc TEXT_LO, bd 0, clr_instr_D 0.
- req, code, epc and bd are combinational from the M registers and from hw_int/im/ie/exl. There is no handshake; CP0 acts in the same cycle.
- Latency:
  - F fault: reaches M 3 edges after fetch.
  - D fault: reaches M 2 edges after decode.
  - E fault: reaches M 1 edge after execute.
- A bubble at M (valid_M=0) blocks the interrupt. The interrupt waits for the next valid instruction.
- exl=1 masks both exceptions and interrupts, and nothing flushes.
- Reset during a flush: reset wins and all registers take reset values.

## Test plan
- pc_F=32'h2ffc with en_D held 1, then nops → code=4, epc=32'h2ffc and req=1 three cycles later; the next cycle has all valid=0.
- Word load with addr_E=32'h7f02 → code=4 at M. Byte store to 32'h7f10 → code=5. Word store to 32'h7f18 → code=5. Word store to 32'h7f14 → req=0.
- Execute stage of add with ovf_E=1 while bd_F was 1 at its fetch, pc=32'h3010 → code=12, bd=1, epc=32'h300c.
- ri_D=1 on an instruction whose F stage already faulted with AdEL → code stays 4. clr_instr_D=1 while that instruction is in D.
- hw_int=6'b000100, im=6'b000100, ie=1, exl=0, M holds an instruction with code 12 → req=1, code=0. Same stimulus with exl=1 → req=0.
- en_D=0 for 3 cycles with clr_E=1 → code_D holds and M sees bubbles with req=0. Then clr_D together with en_D=1 → D is cleared.
